// File: rtl/signed_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, one quotient
// bit per cycle MSB first, followed by a sign-fix cycle. Quotient truncates toward zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the start edge
// CALC  | one restoring step per cycle, WIDTH cycles
// FIX   | sign correction, outputs written, done pulsed
module signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_acc;
  logic             neg_q, neg_r, dz;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shifted never exceeds 2*dvs-1, so the top bit of trial is a clean borrow flag
  always_comb begin
    shifted = {rem_acc, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    fits    = ~trial[WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      dvd_q     <= '0;
      dvs       <= '0;
      rem_acc   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q   <= a[WIDTH-1] ? -a : a;
            dvs     <= b[WIDTH-1] ? -b : b;
            rem_acc <= '0;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
            dz      <= (b == '0);
            count   <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          if (fits) rem_acc <= trial[WIDTH-1:0];
          else      rem_acc <= shifted[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], fits};
          if (count != '0) count <= count - 1'b1;
        end
        FIX: begin
          // a zero divisor leaves |a| in the accumulator, so the normal fix yields remainder = a
          quotient  <= dz ? '1 : (neg_q ? -dvd_q : dvd_q);
          remainder <= neg_r ? -rem_acc : rem_acc;
          div_zero  <= dz;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WIDTH=32): directed corner cases plus
// random operands compared against plain integer arithmetic.
module tb_signed_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  signed_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division as integer arithmetic; remainder follows the dividend sign.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sx, sy, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sy == 0) begin
      q = 32'hFFFF_FFFF; r = x; dz = 1'b1;
    end else begin
      qq = sx / sy;
      rr = sx - qq * sy;
      q = qq[31:0]; r = rr[31:0]; dz = 1'b0;
    end
  endfunction

  // Drive start for one edge (the start edge), then scramble the operands.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait for done, check latency and results; returns #1 after the done edge.
  task automatic wait_check(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eq, er;
    logic edz;
    int n;
    ref_div(x, y, eq, er, edz);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    chk("latency", 32'(n), 32'd33);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", 32'(div_zero), 32'(edz));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  logic [31:0] da[$], db[$];

  initial begin
    int dcnt, first_done;
    logic [31:0] x, y;

    #1;
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_div_zero", 32'(div_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    da = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'h8000_0000, 32'h8000_0000,
           32'd5, -32'sd5, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd3};
    db = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'hFFFF_FFFF, 32'd1,
           32'd0, 32'd0, 32'd0, 32'd5, 32'h8000_0000, 32'd7};
    // back-to-back: each launch happens in the done cycle of the previous divide
    foreach (da[i]) begin
      launch(da[i], db[i]);
      wait_check(da[i], db[i]);
    end

    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? 32'($signed($urandom_range(0, 20)) - 10) : $urandom;
      if (i % 4 == 1) x = 32'($signed($urandom_range(0, 2000)) - 1000);
      launch(x, y);
      wait_check(x, y);
    end

    // start re-pulsed while busy must be ignored
    launch(32'd1000, 32'd3);
    dcnt = 0; first_done = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      @(posedge clk); #1;
      if (n == 10) start = 1'b0;
      if (done) begin
        dcnt++;
        if (first_done == 0) begin
          first_done = n;
          chk("ignored_start_quotient", quotient, 32'd333);
          chk("ignored_start_remainder", remainder, 32'd1);
          launch(32'd9, 32'd9);
          break;
        end
      end
    end
    chk("ignored_start_done_count", 32'(dcnt), 32'd1);
    chk("ignored_start_done_edge", 32'(first_done), 32'd33);
    wait_check(32'd9, 32'd9);

    // results hold until the next done
    repeat (5) @(posedge clk); #1;
    chk("hold_quotient", quotient, 32'd1);
    chk("hold_done", 32'(done), 32'd0);

    // reset mid-divide
    launch(32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_quotient", quotient, 32'd0);
    chk("midreset_remainder", remainder, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no_done_after_reset", 32'(dcnt), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // first start right after a reset release
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    launch(-32'sd1000, 32'd7);
    wait_check(-32'sd1000, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width; all values below assume WIDTH=32.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports as listed in REQ-003 to REQ-011.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 a  input  WIDTH  signed dividend (two's complement).
REQ-007 b  input  WIDTH  signed divisor (two's complement).
REQ-008 quotient  output  WIDTH  signed quotient; registered.
REQ-009 remainder  output  WIDTH  signed remainder; registered.
REQ-010 busy  output  1  high while a divide is in progress.
REQ-011 done  output  1  one-cycle pulse when quotient/remainder are updated; div_zero  output  1  divisor was zero, valid with done.

Function
REQ-012 The block SHALL compute quotient = trunc(a/b), rounded toward zero, and remainder = a - quotient*b, with the remainder sign equal to the dividend sign (or zero).
REQ-013 The FSM SHALL have states IDLE, CALC and FIX; the reset state is IDLE.
REQ-014 In IDLE with start=1, the block SHALL register |a|, |b|, sign(a) XOR sign(b), sign(a) and b==0, load iteration counter = WIDTH-1, and go to CALC.
REQ-015 In CALC, one restoring shift-subtract step (one quotient bit, MSB first) SHALL be done per cycle for exactly WIDTH cycles, then the FSM SHALL go to FIX.
REQ-016 In FIX, the block SHALL apply sign correction (negate the quotient if the signs differed; negate the remainder if the dividend was negative), write quotient, remainder and div_zero, and return to IDLE.
REQ-017 Latency: the start sample is at edge E0, and the outputs SHALL update and done SHALL be high for the single cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32).
REQ-018 busy SHALL be 1 from the edge after the start sample until the FIX edge, and SHALL be 0 in the cycle where done=1.
REQ-019 A new start SHALL be accepted in the same cycle done is high, because the FSM is already in IDLE; back-to-back divides SHALL be supported.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 a and b SHALL be sampled only at the start edge; later changes SHALL have no effect on the result.
REQ-022 Divide by zero SHALL run the full latency and produce quotient={WIDTH{1}}, remainder=a and div_zero=1; otherwise div_zero SHALL be 0.
REQ-023 Overflow case a=most-negative, b=-1 SHALL produce quotient=most-negative (wrap), remainder=0 and div_zero=0.
REQ-024 The magnitude of the most-negative value SHALL be handled as unsigned WIDTH-bit (0x80000000) without loss.
REQ-025 quotient, remainder and div_zero SHALL hold their values until the next done.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force the FSM to IDLE, with quotient=0, remainder=0, busy=0, done=0, div_zero=0 and counter=0.
REQ-027 Reset asserted mid-operation SHALL abandon the divide, and no done SHALL follow after reset release.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-029 a=100, b=7, start pulse -> done 33 edges later; quotient=14, remainder=2, div_zero=0.
REQ-030 Signed cases (-100/7, 100/-7, -100/-7) -> quotient/remainder (-14,-2), (-14,2), (14,-2) respectively.
REQ-031 a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0; and a=0x80000000, b=1 -> quotient=0x80000000, remainder=0.
REQ-032 a=5, b=0 -> after 33 edges: quotient=0xFFFFFFFF, remainder=5, div_zero=1.
REQ-033 Start 1000/3, re-pulse start with 9/9 at cycle 10 -> only one done, at cycle 33, with result 333 r 1; then a new start on the done cycle gives 9/9 = 1 r 0 33 edges later.
REQ-034 Start a divide, assert rst_n=0 at cycle 15 -> all outputs 0 at once, and no done within 40 cycles after release.
